// File: rtl/e15_out_logger.sv
// e15_out_logger: change logger for the e15 controller output vector.
// Timestamped FWFT log with drop accounting and an all-zero watchdog.
module e15_out_logger #(
  parameter int WIDTH      = 20,
  parameter int DEPTH      = 8,
  parameter int TS_W       = 16,
  parameter int IDLE_LIMIT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         y_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_vec,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  output logic                     idle_alarm
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(IDLE_LIMIT + 1);
  localparam logic [IW-1:0] LIM  = IW'(IDLE_LIMIT);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem_vec [DEPTH];
  logic [TS_W-1:0]  mem_ts  [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] prev;
  logic [TS_W-1:0]  ts;
  logic [IW-1:0]    idle_cnt;
  logic [IW-1:0]    idle_nxt;
  logic             active;
  logic             evt;
  logic             pop;
  logic             full;
  logic             push;
  logic             drop;

  assign out_valid = (count != '0);
  assign out_vec   = out_valid ? mem_vec[rd_ptr] : '0;
  assign out_ts    = out_valid ? mem_ts[rd_ptr] : '0;

  always_comb begin
    active   = (state != IDLE);
    evt      = active && (y_in != prev);
    pop      = out_valid && out_ready;
    full     = (count == FULL);
    // a pop in the same cycle frees the slot for a full-FIFO push
    push     = evt && (!full || pop);
    drop     = evt && full && !pop;
    idle_nxt = '0;
    if (y_in == '0)
      idle_nxt = (idle_cnt == LIM) ? idle_cnt
                                   : idle_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_vec[wr_ptr] <= y_in;
      mem_ts[wr_ptr]  <= ts;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      prev       <= '0;
      ts         <= '0;
      idle_cnt   <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      idle_alarm <= 1'b0;
    end else begin
      if (active) begin
        prev <= y_in;
        ts   <= ts + 1'b1;
      end
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (clr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 8'd1;
      end
      if (clr)
        idle_cnt <= '0;
      else if (active)
        idle_cnt <= idle_nxt;
      if (clr)
        idle_alarm <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en)
            state <= RUN;
        end
        RUN: begin
          if (!en)
            state <= IDLE;
          else if (!clr && idle_nxt == LIM) begin
            state      <= STALL;
            idle_alarm <= 1'b1;
          end
        end
        STALL: begin
          if (!en)
            state <= IDLE;
          else if (clr)
            state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
